// File: rtl/pc_pkg.sv
// pc_pkg: types and helpers shared by the PC sequencer and its return-address stack.
//   sel_t        : next-PC source chosen each accepted cycle
//   ras_depth_ok : true when a stack depth is >= 2 and a power of two
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_INC       = 3'd0,
    SEL_RET       = 3'd1,
    SEL_CALL      = 3'd2,
    SEL_BR        = 3'd3,
    SEL_RET_EMPTY = 3'd4
  } sel_t;

  // Power-of-two depth lets the top pointer wrap for free.
  function automatic bit ras_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. When full, a push overwrites the oldest entry.
// Ports:
//   clk, reset      : clock, async active-high reset
//   push, pop       : one-hot requests (the caller never asserts both)
//   push_data       : address written on push
//   top_c           : current top entry (read of registered storage)
//   full, empty     : registered occupancy flags
module pc_ras #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_c,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  tp;
  logic [PTR_W-1:0]  tp_inc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  assign tp_inc = tp + PTR_W'(1);
  assign top_c  = mem[tp];

  // Count saturates at DEPTH on push (overwrite) and never goes below zero.
  always_comb begin
    count_next = count;
    if (push && (count != CNT_W'(DEPTH))) begin
      count_next = count + CNT_W'(1);
    end else if (pop && (count != CNT_W'(0))) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage, pointer and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      tp    <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push) begin
        tp          <= tp_inc;
        mem[tp_inc] <= push_data;
      end else if (pop) begin
        tp <= tp - PTR_W'(1);
      end
      count <= count_next;
      empty <= (count_next == CNT_W'(0));
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch, call/return (via pc_ras) and stall.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   en                          : advance enable; low freezes everything except err_clr
//   branch, branch_addr         : jump request and target
//   call, call_addr             : subroutine call (pushes pc+INC) and target
//   ret                         : return to stack top
//   err_clr                     : clear sticky flags (a same-cycle set wins)
//   pc                          : registered program counter
//   ras_empty, ras_full         : registered stack occupancy
//   ras_overflow, ras_underflow : sticky stack error flags
module pc_sequencer import pc_pkg::*; #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned INC       = 1,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              call,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  if (!ras_depth_ok(RAS_DEPTH)) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be >= 2 and a power of two");
  end

  sel_t              sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ras_top;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  // Wrap-around of pc+INC is intentional and silent.
  assign pc_inc = pc + ADDR_W'(INC);

  // Fixed priority ret > call > branch > increment.
  always_comb begin
    sel = SEL_INC;
    if (ret) begin
      sel = ras_empty ? SEL_RET_EMPTY : SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (branch) begin
      sel = SEL_BR;
    end
  end

  assign push    = en && (sel == SEL_CALL);
  assign pop     = en && (sel == SEL_RET);
  assign ovf_set = push && ras_full;
  assign unf_set = en && (sel == SEL_RET_EMPTY);

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_c     (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_VEC);
    end else if (en) begin
      case (sel)
        SEL_RET:  pc <= ras_top;
        SEL_CALL: pc <= call_addr;
        SEL_BR:   pc <= branch_addr;
        default:  pc <= pc_inc;
      endcase
    end
  end

  // Sticky error flags; err_clr acts regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        ras_overflow <= 1'b1;
      end else if (err_clr) begin
        ras_overflow <= 1'b0;
      end
      if (unf_set) begin
        ras_underflow <= 1'b1;
      end else if (err_clr) begin
        ras_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by random traffic, all checked
// against a queue-based model of the PC and return stack.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MODV   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              branch;
  logic [ADDR_W-1:0] branch_addr;
  logic              call;
  logic [ADDR_W-1:0] call_addr;
  logic              ret;
  logic              err_clr;
  logic [ADDR_W-1:0] pc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (0),
    .INC       (1),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .branch        (branch),
    .branch_addr   (branch_addr),
    .call          (call),
    .call_addr     (call_addr),
    .ret           (ret),
    .err_clr       (err_clr),
    .pc            (pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, stack as a bounded queue (oldest at front).
  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_ovf;
  bit          m_unf;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned wrap(input int unsigned v);
    return v % MODV;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    bit set_o = 1'b0;
    bit set_u = 1'b0;
    if (en) begin
      if (ret) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back();
        end else begin
          m_pc  = wrap(m_pc + 1);
          set_u = 1'b1;
        end
      end else if (call) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          set_o = 1'b1;
        end
        m_stack.push_back(wrap(m_pc + 1));
        m_pc = int'(call_addr);
      end else if (branch) begin
        m_pc = int'(branch_addr);
      end else begin
        m_pc = wrap(m_pc + 1);
      end
    end
    m_ovf = set_o || (m_ovf && !err_clr);
    m_unf = set_u || (m_unf && !err_clr);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stack.size() == 0));
    chk({tag, ".full"}, 32'(ras_full), 32'(m_stack.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic drive(input bit e, input bit b, input int unsigned ba,
                       input bit c, input int unsigned ca, input bit r, input bit clr);
    en          = e;
    branch      = b;
    branch_addr = ADDR_W'(ba);
    call        = c;
    call_addr   = ADDR_W'(ca);
    ret         = r;
    err_clr     = clr;
  endtask

  // One clock: inputs already driven; model advances, outputs sampled #1 after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // 1: count up, then asynchronous reset between edges.
    idle("s1a"); chk("s1a.lit", 32'(pc), 1);
    idle("s1b"); chk("s1b.lit", 32'(pc), 2);
    idle("s1c"); chk("s1c.lit", 32'(pc), 3);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("s1_async_rst");
    chk("s1_async_rst.lit", 32'(pc), 0);
    reset = 1'b0;

    // 2: branch to top of range, wrap, then stall with branch held.
    drive(1, 1, 1023, 0, 0, 0, 0); step("s2_br"); chk("s2_br.lit", 32'(pc), 1023);
    idle("s2_wrap"); chk("s2_wrap.lit", 32'(pc), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 77, 0, 0, 0, 0);
      step("s2_stall");
    end
    chk("s2_stall.lit", 32'(pc), 0);

    // 3: call/ret, then ret wins over call and branch.
    for (int i = 0; i < 5; i++) idle("s3_walk");
    chk("s3_walk.lit", 32'(pc), 5);
    drive(1, 0, 0, 1, 100, 0, 0); step("s3_call"); chk("s3_call.lit", 32'(pc), 100);
    drive(1, 0, 0, 0, 0, 1, 0);   step("s3_ret");  chk("s3_ret.lit", 32'(pc), 6);
    drive(1, 1, 900, 0, 0, 0, 0); step("s3_br5");
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5, 0, 0, 0, 0);
    end
    m_pc = m_pc; // no-op keeps the model in step with the branch below
    drive(1, 1, 5, 0, 0, 0, 0);   step("s3_to5");
    drive(1, 0, 0, 1, 100, 0, 0); step("s3_call2");
    drive(1, 1, 200, 1, 300, 1, 0); step("s3_prio");
    chk("s3_prio.lit", 32'(pc), 6);
    chk("s3_prio.empty", 32'(ras_empty), 1);

    // 4: five nested calls overflow, four rets unwind, fifth underflows.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 1, 10 * i, 0, 0);
      step("s4_call");
    end
    chk("s4_full", 32'(ras_full), 1);
    chk("s4_ovf", 32'(ras_overflow), 1);
    for (int i = 4; i >= 1; i--) begin
      drive(1, 0, 0, 0, 0, 1, 0);
      step("s4_ret");
      chk("s4_ret.lit", 32'(pc), 32'(10 * i + 1));
    end
    drive(1, 0, 0, 0, 0, 1, 0); step("s4_unf");
    chk("s4_unf.lit", 32'(ras_underflow), 1);
    chk("s4_unf.pc", 32'(pc), 12);

    // 5: err_clr while stalled, then err_clr colliding with an underflow.
    drive(0, 0, 0, 0, 0, 0, 1); step("s5_clr");
    chk("s5_clr.ovf", 32'(ras_overflow), 0);
    chk("s5_clr.unf", 32'(ras_underflow), 0);
    chk("s5_clr.pc", 32'(pc), 12);
    drive(1, 0, 0, 0, 0, 1, 1); step("s5_race");
    chk("s5_race.lit", 32'(ras_underflow), 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned k = $urandom_range(0, 99);
      drive(k >= 10,
            $urandom_range(0, 3) == 0, $urandom_range(0, MODV - 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, MODV - 1),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0);
      step("rand");
      if (n == 200) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("rand_rst");
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
